// File: rtl/lc_pkg.sv
// rtl/lc_pkg.sv - shared constants for the sound-core length counters
// Purpose: clock/length-rate constants and default counter widths.
// Ports: none (package).
package lc_pkg;

  localparam int GB_CLK_HZ        = 4194304;
  localparam int LEN_HZ           = 256;
  localparam int LEN_W_SQ         = 6;
  localparam int LEN_W_WAVE       = 8;
  localparam int TICK_DIV_DEFAULT = GB_CLK_HZ / LEN_HZ;

endpackage

// File: rtl/len_counter_bank_if.sv
// rtl/len_counter_bank_if.sv - register/strobe bundle of the length-counter bank
// Purpose: groups per-channel load/trigger/enable controls and status outputs.
// Ports (signals):
//   len_load    NUM_CH*LEN_W  per-channel load value, channel i at [i*LEN_W +: LEN_W]
//   load_we     NUM_CH        1-cycle load strobes
//   trigger     NUM_CH        1-cycle restart strobes
//   len_enable  NUM_CH        length decrement enables (level)
//   dac_off     NUM_CH        DAC-off levels, force channel inactive
//   chan_enable NUM_CH        registered channel-active flags
//   len_tick    1             registered length-tick pulse
interface len_counter_bank_if
  import lc_pkg::*;
#(
  parameter int NUM_CH = 4,
  parameter int LEN_W  = LEN_W_SQ
);

  logic [NUM_CH*LEN_W-1:0] len_load;
  logic [NUM_CH-1:0]       load_we;
  logic [NUM_CH-1:0]       trigger;
  logic [NUM_CH-1:0]       len_enable;
  logic [NUM_CH-1:0]       dac_off;
  logic [NUM_CH-1:0]       chan_enable;
  logic                    len_tick;

  modport master (
    output len_load, load_we, trigger, len_enable, dac_off,
    input  chan_enable, len_tick
  );

  modport slave (
    input  len_load, load_we, trigger, len_enable, dac_off,
    output chan_enable, len_tick
  );

endinterface

// File: rtl/len_counter_ch.sv
// rtl/len_counter_ch.sv - one channel's length counter and active flag
// Purpose: counter load/decrement/trigger-reload with optional
//          frame-sequencer phase quirks.
// Ports:
//   clk, rst_n   clock, async active-low reset
//   tick         prescaler terminal count (counters clock this cycle)
//   half         1 when the last sequencer step clocked length
//   len_load     load value; counter becomes 2^LEN_W - len_load
//   load_we      load strobe
//   trigger      channel restart strobe
//   len_enable   length decrement enable
//   dac_off      forces chan_enable low
//   chan_enable  registered channel-active flag
module len_counter_ch
  import lc_pkg::*;
#(
  parameter int LEN_W  = LEN_W_SQ,
  parameter int QUIRKS = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             tick,
  input  logic             half,
  input  logic [LEN_W-1:0] len_load,
  input  logic             load_we,
  input  logic             trigger,
  input  logic             len_enable,
  input  logic             dac_off,
  output logic             chan_enable
);

  localparam int CW = LEN_W + 1;
  localparam logic [CW-1:0] FULL = CW'(1) << LEN_W;
  localparam logic QK = (QUIRKS != 0);

  logic [CW-1:0] count, count_nx;
  logic          ce_nx;
  logic          en_q;
  logic          extra_clk;
  logic          clocked;
  logic          hit_zero;

  always_comb begin
    count_nx = count;
    ce_nx    = chan_enable;
    hit_zero = 1'b0;
    // Enabling length during the half of the frame whose step already
    // clocked length makes the counter see that clock late.
    extra_clk = QK && len_enable && !en_q && half;
    clocked   = (tick && len_enable) || extra_clk;

    if (load_we) begin
      count_nx = FULL - {1'b0, len_load};
    end else if (clocked && (count != '0)) begin
      count_nx = count - CW'(1);
      hit_zero = (count == CW'(1));
    end

    // Reload tests the post-decrement value so a trigger racing expiry
    // still restarts; loaded values are never zero so load wins.
    if (trigger && (count_nx == '0)) begin
      count_nx = (QK && len_enable && half) ? FULL - CW'(1) : FULL;
    end

    if (trigger) begin
      ce_nx = 1'b1;
    end else if (hit_zero) begin
      ce_nx = 1'b0;
    end
    if (dac_off) begin
      ce_nx = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count       <= '0;
      chan_enable <= 1'b0;
      en_q        <= 1'b0;
    end else begin
      count       <= count_nx;
      chan_enable <= ce_nx;
      en_q        <= len_enable;
    end
  end

endmodule

// File: rtl/len_counter_bank.sv
// rtl/len_counter_bank.sv - shared 256 Hz prescaler driving NUM_CH length counters
// Purpose: prescaler generates tick/half; one len_counter_ch per channel.
// Ports:
//   clk, rst_n  clock, async active-low reset
//   bus         len_counter_bank_if.slave (controls in, chan_enable/len_tick out)
module len_counter_bank
  import lc_pkg::*;
#(
  parameter int NUM_CH   = 4,
  parameter int LEN_W    = LEN_W_SQ,
  parameter int TICK_DIV = TICK_DIV_DEFAULT,
  parameter int QUIRKS   = 1
) (
  input logic               clk,
  input logic               rst_n,
  len_counter_bank_if.slave bus
);

  localparam int PRE_W = $clog2(TICK_DIV);

  logic [PRE_W-1:0]  pre;
  logic              tick;
  logic              half;
  logic              tick_q;
  logic [NUM_CH-1:0] chan_en;

  assign tick = (pre == PRE_W'(TICK_DIV - 1));
  // First half of the period follows the step that clocked length.
  assign half = (pre < PRE_W'(TICK_DIV / 2));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pre    <= '0;
      tick_q <= 1'b0;
    end else begin
      pre    <= tick ? '0 : pre + PRE_W'(1);
      tick_q <= tick;
    end
  end

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    len_counter_ch #(
      .LEN_W  (LEN_W),
      .QUIRKS (QUIRKS)
    ) u_ch (
      .clk         (clk),
      .rst_n       (rst_n),
      .tick        (tick),
      .half        (half),
      .len_load    (bus.len_load[g*LEN_W +: LEN_W]),
      .load_we     (bus.load_we[g]),
      .trigger     (bus.trigger[g]),
      .len_enable  (bus.len_enable[g]),
      .dac_off     (bus.dac_off[g]),
      .chan_enable (chan_en[g])
    );
  end

  assign bus.chan_enable = chan_en;
  assign bus.len_tick    = tick_q;

endmodule

// File: tb/tb_len_counter_bank.sv
// tb/tb_len_counter_bank.sv - scoreboard bench for len_counter_bank
module tb_len_counter_bank;
  localparam int TD = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  len_counter_bank_if #(.NUM_CH(4), .LEN_W(6)) bus_a ();
  len_counter_bank_if #(.NUM_CH(4), .LEN_W(6)) bus_b ();
  len_counter_bank_if #(.NUM_CH(4), .LEN_W(8)) bus_c ();

  len_counter_bank #(.NUM_CH(4), .LEN_W(6), .TICK_DIV(TD), .QUIRKS(1)) dut_a (
    .clk(clk), .rst_n(rst_n), .bus(bus_a));
  len_counter_bank #(.NUM_CH(4), .LEN_W(6), .TICK_DIV(TD), .QUIRKS(0)) dut_b (
    .clk(clk), .rst_n(rst_n), .bus(bus_b));
  len_counter_bank #(.NUM_CH(4), .LEN_W(8), .TICK_DIV(TD), .QUIRKS(1)) dut_c (
    .clk(clk), .rst_n(rst_n), .bus(bus_c));

  logic [3:0][8:0] cnt_a, cnt_b, cnt_c;
  for (genvar g = 0; g < 4; g++) begin : g_peek
    assign cnt_a[g] = {2'b00, dut_a.g_ch[g].u_ch.count};
    assign cnt_b[g] = {2'b00, dut_b.g_ch[g].u_ch.count};
    assign cnt_c[g] = dut_c.g_ch[g].u_ch.count;
  end

  typedef struct packed {
    logic [2:0][3:0]      ce;
    logic                 tick;
    logic [2:0][3:0][8:0] cnt;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  // stimulus for the next edge
  bit       s_rst;
  bit [3:0] s_ld, s_trg, s_en, s_dac;
  bit [7:0] s_val[4];

  // reference state: dut index 0 = 6-bit quirky, 1 = 6-bit plain, 2 = 8-bit quirky
  int m_pre;
  bit m_tick;
  int m_cnt[3][4];
  bit m_ce[3][4];
  bit m_prev[3][4];

  function automatic int lw(int k);
    return (k == 2) ? 8 : 6;
  endfunction

  function automatic bit qk(int k);
    return k != 1;
  endfunction

  task automatic chk(input string nm, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0d expected %0d", nm, $time, act, exp);
    end
  endtask

  task automatic model_step();
    exp_t e;
    bit tick, half, hit0;
    int full, v, c0;
    if (s_rst) begin
      m_pre  = 0;
      m_tick = 0;
      for (int k = 0; k < 3; k++)
        for (int c = 0; c < 4; c++) begin
          m_cnt[k][c] = 0; m_ce[k][c] = 0; m_prev[k][c] = 0;
        end
    end else begin
      tick = (m_pre == TD - 1);
      half = (m_pre < TD / 2);
      for (int k = 0; k < 3; k++)
        for (int c = 0; c < 4; c++) begin
          full = 1 << lw(k);
          v    = int'(s_val[c]) % full;
          c0   = m_cnt[k][c];
          hit0 = 0;
          if (s_ld[c]) c0 = full - v;
          else if (c0 > 0 && s_en[c] &&
                   (tick || (qk(k) && half && !m_prev[k][c]))) begin
            c0 = c0 - 1;
            hit0 = (c0 == 0);
          end
          if (s_trg[c] && c0 == 0)
            c0 = (qk(k) && s_en[c] && half) ? full - 1 : full;
          if (s_dac[c]) m_ce[k][c] = 0;
          else if (s_trg[c]) m_ce[k][c] = 1;
          else if (hit0) m_ce[k][c] = 0;
          m_cnt[k][c]  = c0;
          m_prev[k][c] = s_en[c];
        end
      m_tick = tick;
      m_pre  = (m_pre + 1) % TD;
    end
    e.tick = m_tick;
    for (int k = 0; k < 3; k++)
      for (int c = 0; c < 4; c++) begin
        e.ce[k][c]  = m_ce[k][c];
        e.cnt[k][c] = 9'(m_cnt[k][c]);
      end
    exp_q.push_back(e);
  endtask

  task automatic cyc();
    logic [23:0] la;
    logic [31:0] lc;
    @(negedge clk);
    for (int c = 0; c < 4; c++) begin
      la[c*6 +: 6] = s_val[c][5:0];
      lc[c*8 +: 8] = s_val[c];
    end
    rst_n = !s_rst;
    bus_a.len_load = la; bus_b.len_load = la; bus_c.len_load = lc;
    bus_a.load_we = s_ld;  bus_b.load_we = s_ld;  bus_c.load_we = s_ld;
    bus_a.trigger = s_trg; bus_b.trigger = s_trg; bus_c.trigger = s_trg;
    bus_a.len_enable = s_en; bus_b.len_enable = s_en; bus_c.len_enable = s_en;
    bus_a.dac_off = s_dac; bus_b.dac_off = s_dac; bus_c.dac_off = s_dac;
    model_step();
    s_ld  = '0;
    s_trg = '0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc();
  endtask

  task automatic wait_pre(input int p);
    for (int i = 0; i < TD && m_pre != p; i++) cyc();
  endtask

  // monitor: one expected record per clock edge
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        chk("len_tick_a", int'(bus_a.len_tick), int'(e.tick));
        chk("len_tick_b", int'(bus_b.len_tick), int'(e.tick));
        chk("len_tick_c", int'(bus_c.len_tick), int'(e.tick));
        for (int c = 0; c < 4; c++) begin
          chk($sformatf("ce_a%0d", c), int'(bus_a.chan_enable[c]), int'(e.ce[0][c]));
          chk($sformatf("ce_b%0d", c), int'(bus_b.chan_enable[c]), int'(e.ce[1][c]));
          chk($sformatf("ce_c%0d", c), int'(bus_c.chan_enable[c]), int'(e.ce[2][c]));
          chk($sformatf("cnt_a%0d", c), int'(cnt_a[c]), int'(e.cnt[0][c]));
          chk($sformatf("cnt_b%0d", c), int'(cnt_b[c]), int'(e.cnt[1][c]));
          chk($sformatf("cnt_c%0d", c), int'(cnt_c[c]), int'(e.cnt[2][c]));
        end
      end
    end
  end

  initial begin
    s_rst = 1; s_ld = '0; s_trg = '0; s_en = '0; s_dac = '0;
    for (int c = 0; c < 4; c++) s_val[c] = '0;
    bus_a.len_load = '0; bus_b.len_load = '0; bus_c.len_load = '0;
    bus_a.load_we = '0; bus_b.load_we = '0; bus_c.load_we = '0;
    bus_a.trigger = '0; bus_b.trigger = '0; bus_c.trigger = '0;
    bus_a.len_enable = '0; bus_b.len_enable = '0; bus_c.len_enable = '0;
    bus_a.dac_off = '0; bus_b.dac_off = '0; bus_c.dac_off = '0;

    // reset for 3 cycles, then free-run the prescaler
    idle(3);
    s_rst = 0;
    idle(30);

    // quirk trigger reload on counters still 0 from reset
    s_en = 4'b1100;
    wait_pre(2); s_trg = 4'b0100; cyc();
    wait_pre(6); s_trg = 4'b1000; cyc();

    // basic expiry on ch0: load 60, trigger, enable
    s_val[0] = 8'd60; s_ld = 4'b0001; cyc();
    s_trg = 4'b0001; s_en[0] = 1; cyc();
    idle(50);

    // quirk extra clock on ch1: count 1, enable rising at pre=1, then at pre=5
    s_en[1] = 0; s_val[1] = 8'd63; s_ld = 4'b0010; s_trg = 4'b0010; cyc();
    wait_pre(1); s_en[1] = 1; cyc();
    idle(4);
    s_en[1] = 0; s_ld = 4'b0010; s_trg = 4'b0010; cyc();
    wait_pre(5); s_en[1] = 1; cyc();
    idle(12);

    // trigger coinciding with decrement to 0
    s_ld = 4'b0010; cyc();
    wait_pre(7); s_trg = 4'b0010; cyc();
    idle(4);

    // load and trigger together, then wave-width load of 0
    s_val[3] = 8'd0; s_ld = 4'b1000; s_trg = 4'b1000; cyc();
    idle(4);

    // dac_off on ch2 while its counter expires and is retriggered
    s_en[2] = 0; s_val[2] = 8'd255; s_ld = 4'b0100; cyc();
    s_en[2] = 1; s_dac = 4'b0100;
    idle(20);
    wait_pre(5); s_trg = 4'b0100; cyc();
    idle(4);
    s_dac = 4'b0000;
    idle(4);

    // randomized traffic with occasional mid-run reset
    for (int i = 0; i < 3000; i++) begin
      for (int c = 0; c < 4; c++) begin
        s_val[c] = 8'($urandom_range(0, 255));
        s_ld[c]  = ($urandom_range(0, 39) == 0);
        s_trg[c] = ($urandom_range(0, 29) == 0);
        if ($urandom_range(0, 24) == 0) s_en[c] = !s_en[c];
        if ($urandom_range(0, 59) == 0) s_dac[c] = !s_dac[c];
      end
      s_rst = ($urandom_range(0, 1499) == 0);
      cyc();
    end
    s_rst = 0;
    idle(4);

    repeat (2) @(posedge clk);
    #2;
    chk("scoreboard_drained", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/len_counter_bank.md
# len_counter_bank

Multi-channel length-counter bank for the sound core: one shared 256 Hz length-tick prescaler driving NUM_CH independent, parametrised-width length counters. Each channel's counter is loaded by register write and reloaded on trigger. Each counter decrements on the length tick when enabled and gates its channel off at expiry. Optional hardware-accurate quirk mode models the extra-clock and trigger-reload behaviour tied to frame-sequencer phase.

## Interface
- NUM_CH, default 4: number of channels.
- LEN_W, default 6: length-load width; the counter holds 0..2^LEN_W. Use 6 for pulse/noise and 8 for wave.
- TICK_DIV, default 16384: clk cycles per length tick (4.194304 MHz / 256 Hz). Must be even and ≥4.
- QUIRKS, default 1: 1 enables phase-dependent extra-clock/reload behaviour; 0 gives plain behaviour.

- clk  in  1  system clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- len_load  in  NUM_CH*LEN_W  per-channel load value; channel i occupies bits [i*LEN_W +: LEN_W].
- load_we  in  NUM_CH  1-cycle strobe: counter_i ← 2^LEN_W − len_load_i.
- trigger  in  NUM_CH  1-cycle strobe: channel restart.
- len_enable  in  NUM_CH  level: length decrement enabled.
- dac_off  in  NUM_CH  level: forces chan_enable_i low and blocks trigger from setting it.
- chan_enable  out  NUM_CH  registered channel-active flag.
- len_tick  out  1  registered 1-cycle pulse, asserted on the cycle the counters are clocked.

## Operation
- **Prescaler:**
  - `pre` counts 0..TICK_DIV−1 and wraps.
  - `tick` = (pre == TICK_DIV−1).
  - `half` = (pre < TICK_DIV/2), meaning the most recent sequencer step clocked length.
- **Counter width:** LEN_W+1 bits, range 0..2^LEN_W.
  - Load math is 2^LEN_W − len_load, giving 1..2^LEN_W. It is never 0.
- **Per-channel priority within one cycle**, highest first:
  1. load_we
  2. decrement (tick, or quirk extra clock)
  3. trigger reload

  Load and trigger in the same cycle: the load value is used, and trigger does not reload because the loaded count is nonzero.
- **Decrement:** on tick, when len_enable_i=1 and counter≠0, counter−1. A decrement to 0 clears chan_enable_i unless trigger_i is asserted in the same cycle.
- **Trigger:**
  - If counter==0, reload to 2^LEN_W.
  - Sets chan_enable_i=1 unless dac_off_i=1.
  - A trigger on the same cycle as a decrement-to-0 reloads.
- **Quirk 1 (QUIRKS=1): extra clock.**
  - Condition: rising edge of len_enable_i (registered previous value is 0, current is 1) while half=1 and counter≠0.
  - Action: one extra decrement.
  - If this reaches 0 and there is no trigger in the same cycle, clear chan_enable_i.
  - The extra clock never coincides with tick, because tick occurs only when half=0.
- **Quirk 2 (QUIRKS=1): trigger reload.**
  - Condition: trigger with counter==0, len_enable_i=1 and half=1.
  - Action: reload to 2^LEN_W − 1 instead of 2^LEN_W.
- **QUIRKS=0:** neither quirk applies.
- **dac_off:** while dac_off_i=1, chan_enable_i=0. The counter continues to operate normally.
- **Disabled counting:** a channel with len_enable_i=0 holds its count indefinitely. chan_enable_i is unaffected.

## Timing
- **Reset:** asynchronous. Values while in reset:
  - pre=0, every counter=0, every chan_enable=0, len_tick=0, len_enable history=0.
- **Release:** the first tick occurs TICK_DIV cycles after rst_n deasserts.
- **Latency:** all outputs are registered. An event at edge N (load, trigger, tick, enable edge) is visible on chan_enable and in the counters after edge N.
- **len_tick:** high for exactly one cycle out of every TICK_DIV, on the cycle the counters decrement.
- **Mid-operation reset:** all state clears immediately. No partial decrement completes.
- **Wrap-around:** counters never underflow below 0 and never exceed 2^LEN_W.

## Structure
- **Shared package lc_pkg**, holding:
  - GB_CLK_HZ=4194304
  - LEN_HZ=256
  - LEN_W_SQ=6
  - LEN_W_WAVE=8
  - TICK_DIV_DEFAULT
- **Sub-module len_counter_ch:**
  - One instance per channel.
  - Holds the counter, the chan_enable flag and the len_enable history.
  - Takes tick and half from the parent.
- **Top level:** the prescaler plus a generate loop over NUM_CH.

## Test plan
All scenarios use TICK_DIV=8.
- **Reset/prescaler:** hold rst_n low for 3 cycles, then release. Required: all outputs 0; len_tick pulses at cycles 8, 16, 24; it is never high for 2 consecutive cycles.
- **Basic expiry:** LEN_W=6, load 60 (count 4), trigger, len_enable=1. Required:
  - chan_enable=1 the cycle after trigger.
  - chan_enable falls on the 4th len_tick.
  - Further ticks leave the count at 0.
- **Max reload and simultaneity:**
  - Trigger with counter=0 and QUIRKS=0: count=64.
  - Trigger on the same cycle as a decrement-to-0: chan_enable stays 1 and count=64.
  - LEN_W=8 with load 0: count=256.
- **Quirk extra clock:** QUIRKS=1, count=1, len_enable 0→1 at pre=1 (half=1). Required: count=0 and chan_enable=0 the next cycle. Repeating at pre=5 (half=0) leaves the count unchanged.
- **Quirk trigger reload:** QUIRKS=1, counter=0, len_enable=1, trigger at pre=2. Required: count=63 with LEN_W=6. The same trigger at pre=6 gives count=64.
- **dac_off:** dac_off_2=1, then trigger channel 2. Required: chan_enable_2 stays 0, the counter still reloads, and the other channels are unaffected.
